// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller:
// opcode/funct values, FSM states, datapath select codes and the output bundle.
package ctrl_defs;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_BGEZAL = 6'b000001;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_ADDU   = 6'b100001;
  localparam logic [5:0] FN_SUBU   = 6'b100011;
  localparam logic [5:0] FN_JR     = 6'b001000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB_ALU = 3'd5,
    S_WB_MEM = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JAL    = 2'b10;
  localparam logic [1:0] NPC_GPR    = 2'b11;

  localparam logic [1:0] M2R_ALU    = 2'b00;
  localparam logic [1:0] M2R_DM     = 2'b01;
  localparam logic [1:0] M2R_LINK   = 2'b10;

  localparam logic [1:0] DST_RT     = 2'b00;
  localparam logic [1:0] DST_RD     = 2'b01;
  localparam logic [1:0] DST_RA     = 2'b10;

  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN   = 2'b01;
  localparam logic [1:0] EXT_LUI    = 2'b10;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_OR     = 3'b010;
  localparam logic [2:0] ALU_SLT    = 3'b100;

  // Exactly one field is set for any encoding; unknown encodings land in nop.
  typedef struct packed {
    logic rcal;
    logic jr;
    logic ical;
    logic load;
    logic store;
    logic beq;
    logic bgezal;
    logic jal;
    logic nop;
  } iclass_t;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] extop;
    logic [2:0] aluop;
  } exe_sel_t;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic [1:0] regdst;
    logic       alusrc;
    logic [1:0] memtoreg;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] extop;
    logic [1:0] npc_sel;
    logic [2:0] aluop;
    logic       if_lb;
    logic       if_sb;
    logic       instr_done;
  } ctrl_out_t;

  function automatic exe_sel_t exe_sel(logic [5:0] op, logic [5:0] func);
    exe_sel_t s;
    s = '0;
    case (op)
      OP_R_TYPE:               s.aluop = (func == FN_SUBU) ? ALU_SUB : ALU_ADD;
      OP_ORI:                  s = '{alusrc: 1'b1, extop: EXT_ZERO, aluop: ALU_OR};
      OP_LUI:                  s = '{alusrc: 1'b1, extop: EXT_LUI,  aluop: ALU_ADD};
      OP_SLTI:                 s = '{alusrc: 1'b1, extop: EXT_SIGN, aluop: ALU_SLT};
      OP_LW, OP_LB, OP_SW, OP_SB:
                               s = '{alusrc: 1'b1, extop: EXT_SIGN, aluop: ALU_ADD};
      OP_BEQ:                  s.aluop = ALU_SUB;
      default:                 s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR contents and flags in, selects and strobes out.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        bgezal_op;
  logic        mem_ready;
  logic        pc_we;
  logic        ir_we;
  logic [1:0]  regdst;
  logic        alusrc;
  logic [1:0]  memtoreg;
  logic        memwrite;
  logic        regwrite;
  logic [1:0]  extop;
  logic [1:0]  npc_sel;
  logic [2:0]  aluop;
  logic        if_lb;
  logic        if_sb;
  logic        instr_done;
  logic [2:0]  state;

  modport master (
    input  instr, zero, bgezal_op, mem_ready,
    output pc_we, ir_we, regdst, alusrc, memtoreg, memwrite, regwrite,
           extop, npc_sel, aluop, if_lb, if_sb, instr_done, state
  );

  modport slave (
    output instr, zero, bgezal_op, mem_ready,
    input  pc_we, ir_we, regdst, alusrc, memtoreg, memwrite, regwrite,
           extop, npc_sel, aluop, if_lb, if_sb, instr_done, state
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: op/func to a one-hot class plus a byte-access flag.
module instr_class_decode
  import ctrl_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    cls,
  output logic       is_byte
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    cls     = '0;
    is_byte = 1'b0;
    case (op)
      OP_R_TYPE: begin
        if (func == FN_ADDU || func == FN_SUBU) cls.rcal = 1'b1;
        else if (func == FN_JR)                 cls.jr   = 1'b1;
        else                                    cls.nop  = 1'b1;
      end
      OP_ORI, OP_LUI, OP_SLTI: cls.ical   = 1'b1;
      OP_LW:                   cls.load   = 1'b1;
      OP_LB:     begin         cls.load   = 1'b1; is_byte = 1'b1; end
      OP_SW:                   cls.store  = 1'b1;
      OP_SB:     begin         cls.store  = 1'b1; is_byte = 1'b1; end
      OP_BEQ:                  cls.beq    = 1'b1;
      OP_BGEZAL:               cls.bgezal = 1'b1;
      OP_JAL:                  cls.jal    = 1'b1;
      default:                 cls.nop    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: steps each instruction through fetch/decode/exe/mem/wb
// and drives the datapath selects and write strobes for the current step only.
module multicycle_ctrl
  import ctrl_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_t    state_q;
  state_t    state_d;
  iclass_t   cls;
  logic      is_byte;
  exe_sel_t  sel;
  ctrl_out_t o;
  logic      show_sel;

  instr_class_decode u_decode (
    .op      (bus.instr[31:26]),
    .func    (bus.instr[5:0]),
    .cls     (cls),
    .is_byte (is_byte)
  );

  assign sel = exe_sel(bus.instr[31:26], bus.instr[5:0]);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    o        = '0;
    show_sel = 1'b0;
    state_d  = S_FETCH;
    case (state_q)
      S_FETCH: begin
        o.ir_we   = 1'b1;
        o.pc_we   = 1'b1;
        o.npc_sel = NPC_PC4;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXE;
        if (cls.jal) begin
          o.pc_we      = 1'b1;
          o.npc_sel    = NPC_JAL;
          o.regwrite   = 1'b1;
          o.regdst     = DST_RA;
          o.memtoreg   = M2R_LINK;
          o.instr_done = 1'b1;
          state_d      = S_FETCH;
        end else if (cls.jr) begin
          o.pc_we      = 1'b1;
          o.npc_sel    = NPC_GPR;
          o.instr_done = 1'b1;
          state_d      = S_FETCH;
        end else if (cls.nop) begin
          o.instr_done = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXE: begin
        show_sel = 1'b1;
        if (cls.beq) begin
          o.pc_we      = bus.zero;
          o.npc_sel    = NPC_BRANCH;
          o.instr_done = 1'b1;
          state_d      = S_FETCH;
        end else if (cls.bgezal) begin
          // Link and branch together; PC already holds PC+4 for the link value.
          if (bus.bgezal_op) begin
            o.pc_we    = 1'b1;
            o.npc_sel  = NPC_BRANCH;
            o.regwrite = 1'b1;
            o.regdst   = DST_RA;
            o.memtoreg = M2R_LINK;
          end
          o.instr_done = 1'b1;
          state_d      = S_FETCH;
        end else if (cls.load) begin
          state_d = S_MEM_RD;
        end else if (cls.store) begin
          state_d = S_MEM_WR;
        end else if (cls.rcal || cls.ical) begin
          state_d = S_WB_ALU;
        end
      end
      S_MEM_RD: begin
        show_sel = 1'b1;
        o.if_lb  = is_byte;
        state_d  = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        show_sel     = 1'b1;
        o.memwrite   = 1'b1;
        o.if_sb      = is_byte;
        o.instr_done = bus.mem_ready;
        state_d      = bus.mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_WB_ALU: begin
        show_sel     = 1'b1;
        o.regwrite   = 1'b1;
        o.memtoreg   = M2R_ALU;
        o.regdst     = cls.rcal ? DST_RD : DST_RT;
        o.instr_done = 1'b1;
      end
      S_WB_MEM: begin
        show_sel     = 1'b1;
        o.regwrite   = 1'b1;
        o.memtoreg   = M2R_DM;
        o.regdst     = DST_RT;
        o.if_lb      = is_byte;
        o.instr_done = 1'b1;
      end
      default: begin
        o       = '0;
        state_d = S_FETCH;
      end
    endcase

    // ALU operand selects stay stable from execute until the instruction retires.
    if (show_sel) begin
      o.alusrc = sel.alusrc;
      o.extop  = sel.extop;
      o.aluop  = sel.aluop;
    end

    // Reset silences every strobe at once, including a pending DM write.
    if (reset) o = '0;
  end

  assign bus.pc_we      = o.pc_we;
  assign bus.ir_we      = o.ir_we;
  assign bus.regdst     = o.regdst;
  assign bus.alusrc     = o.alusrc;
  assign bus.memtoreg   = o.memtoreg;
  assign bus.memwrite   = o.memwrite;
  assign bus.regwrite   = o.regwrite;
  assign bus.extop      = o.extop;
  assign bus.npc_sel    = o.npc_sel;
  assign bus.aluop      = o.aluop;
  assign bus.if_lb      = o.if_lb;
  assign bus.if_sb      = o.if_sb;
  assign bus.instr_done = o.instr_done;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle comparison against a mnemonic-level timeline model.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {
    M_ADDU, M_SUBU, M_JR, M_ORI, M_LUI, M_SLTI, M_LW,
    M_LB, M_SW, M_SB, M_BEQ, M_BGEZAL, M_JAL, M_NOP
  } mn_t;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_we;
    logic       ir_we;
    logic [1:0] regdst;
    logic       alusrc;
    logic [1:0] memtoreg;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] extop;
    logic [1:0] npc_sel;
    logic [2:0] aluop;
    logic       if_lb;
    logic       if_sb;
    logic       instr_done;
  } obs_t;

  localparam obs_t OBS_RESET = '0;

  obs_t exp_q[$];
  obs_t seen[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  function automatic obs_t sample();
    obs_t a;
    a.state      = bus.state;
    a.pc_we      = bus.pc_we;
    a.ir_we      = bus.ir_we;
    a.regdst     = bus.regdst;
    a.alusrc     = bus.alusrc;
    a.memtoreg   = bus.memtoreg;
    a.memwrite   = bus.memwrite;
    a.regwrite   = bus.regwrite;
    a.extop      = bus.extop;
    a.npc_sel    = bus.npc_sel;
    a.aluop      = bus.aluop;
    a.if_lb      = bus.if_lb;
    a.if_sb      = bus.if_sb;
    a.instr_done = bus.instr_done;
    return a;
  endfunction

  // Instruction length in cycles, n = number of cycles mem_ready is held low.
  function automatic int cycles_of(mn_t m, int n);
    case (m)
      M_JAL, M_JR, M_NOP: return 2;
      M_BEQ, M_BGEZAL:    return 3;
      M_LW, M_LB:         return 5 + n;
      M_SW, M_SB:         return 4 + n;
      default:            return 4;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = fetch) of an instruction lasting len cycles.
  function automatic obs_t expect_cycle(mn_t m, int k, int len, bit z, bit bg);
    obs_t       e;
    logic [5:0] s;
    bit         is_load  = (m == M_LW || m == M_LB);
    bit         is_store = (m == M_SW || m == M_SB);
    e = '0;
    case (m)
      M_SUBU:                  s = 6'b0_00_001;
      M_ORI:                   s = 6'b1_00_010;
      M_LUI:                   s = 6'b1_10_000;
      M_SLTI:                  s = 6'b1_01_100;
      M_LW, M_LB, M_SW, M_SB:  s = 6'b1_01_000;
      M_BEQ:                   s = 6'b0_00_001;
      default:                 s = 6'b0_00_000;
    endcase
    e.instr_done = (k == len - 1);
    if (k == 0) begin
      e.state = 3'd0; e.ir_we = 1'b1; e.pc_we = 1'b1;
    end else if (k == 1) begin
      e.state = 3'd1;
      if (m == M_JAL) begin
        e.pc_we = 1'b1; e.npc_sel = 2'b10; e.regwrite = 1'b1;
        e.regdst = 2'b10; e.memtoreg = 2'b10;
      end else if (m == M_JR) begin
        e.pc_we = 1'b1; e.npc_sel = 2'b11;
      end
    end else begin
      {e.alusrc, e.extop, e.aluop} = s;
      if (k == 2) begin
        e.state = 3'd2;
        if (m == M_BEQ) begin
          e.pc_we = z; e.npc_sel = 2'b01;
        end else if (m == M_BGEZAL && bg) begin
          e.pc_we = 1'b1; e.npc_sel = 2'b01; e.regwrite = 1'b1;
          e.regdst = 2'b10; e.memtoreg = 2'b10;
        end
      end else if (is_load && k < len - 1) begin
        e.state = 3'd3; e.if_lb = (m == M_LB);
      end else if (is_load) begin
        e.state = 3'd6; e.regwrite = 1'b1; e.memtoreg = 2'b01; e.if_lb = (m == M_LB);
      end else if (is_store) begin
        e.state = 3'd4; e.memwrite = 1'b1; e.if_sb = (m == M_SB);
      end else begin
        e.state = 3'd5; e.regwrite = 1'b1;
        e.regdst = (m == M_ADDU || m == M_SUBU) ? 2'b01 : 2'b00;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] make_instr(mn_t m);
    logic [31:0] w = $urandom;
    logic [5:0]  f;
    case (m)
      M_ADDU:   begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
      M_SUBU:   begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
      M_JR:     begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
      M_ORI:    w[31:26] = 6'h0D;
      M_LUI:    w[31:26] = 6'h0F;
      M_SLTI:   w[31:26] = 6'h0A;
      M_LW:     w[31:26] = 6'h23;
      M_LB:     w[31:26] = 6'h20;
      M_SW:     w[31:26] = 6'h2B;
      M_SB:     w[31:26] = 6'h28;
      M_BEQ:    w[31:26] = 6'h04;
      M_BGEZAL: begin w[31:26] = 6'h01; w[20:16] = 5'h11; end
      M_JAL:    w[31:26] = 6'h03;
      default: begin
        f = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) begin
          if (f inside {6'h21, 6'h23, 6'h08}) f = 6'h3F;
          w[31:26] = 6'h00; w[5:0] = f;
        end else begin
          if (f inside {6'h00, 6'h01, 6'h03, 6'h04, 6'h0A, 6'h0D, 6'h0F,
                        6'h20, 6'h23, 6'h28, 6'h2B}) f = 6'h3F;
          w[31:26] = f;
        end
      end
    endcase
    return w;
  endfunction

  // Compare process: one expected record per cycle, checked mid-cycle.
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample();
      seen.push_back(a);
      check("cycle_outputs", {10'd0, a}, {10'd0, e});
    end
  end

  // Called just after an edge that entered fetch; returns just after the edge that
  // re-enters fetch. abort_k >= 0 asserts reset in that cycle instead.
  task automatic run_instr(input mn_t m, input logic [31:0] ins, input int n,
                           input bit z, input bit bg, input int abort_k);
    int len = cycles_of(m, n);
    bit in_store_wait;
    for (int k = 0; k < len; k++) begin
      bus.instr     = (k == 0) ? $urandom : ins;
      bus.zero      = (k == 2) ? z  : 1'($urandom);
      bus.bgezal_op = (k == 2) ? bg : 1'($urandom);
      bus.mem_ready = (k < 3) ? 1'($urandom) : (k >= 3 + n);
      if (k == abort_k) begin
        in_store_wait = (m == M_SW || m == M_SB) && k >= 3;
        if (in_store_wait) begin
          #1 check("store_wait_memwrite", 32'(bus.memwrite), 32'd1);
        end
        reset = 1'b1;
        #1;
        if (in_store_wait) begin
          check("abort_memwrite", 32'(bus.memwrite), 32'd0);
          check("abort_state", 32'(bus.state), 32'd0);
        end
        exp_q.push_back(OBS_RESET);
        @(posedge clk); #1;
        exp_q.push_back(OBS_RESET);
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      exp_q.push_back(expect_cycle(m, k, len, z, bg));
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] state_trace();
    logic [31:0] v = '0;
    foreach (seen[i]) v = (v << 4) | 32'(seen[i].state);
    return v;
  endfunction

  function automatic int done_count();
    int c = 0;
    foreach (seen[i]) c += int'(seen[i].instr_done);
    return c;
  endfunction

  initial begin
    mn_t m;
    int  n;
    int  len;
    int  abort_k;

    reset         = 1'b1;
    bus.instr     = 32'h0;
    bus.zero      = 1'b0;
    bus.bgezal_op = 1'b0;
    bus.mem_ready = 1'b0;

    @(posedge clk); #1;
    repeat (3) begin
      exp_q.push_back(OBS_RESET);
      #1 check("reset_ir_we", 32'(bus.ir_we), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    // addu $3,$1,$2
    seen.delete();
    run_instr(M_ADDU, 32'h00221821, 0, 1'b0, 1'b0, -1);
    check("addu_states", state_trace(), 32'h0125);
    check("addu_done_count", done_count(), 1);
    check("addu_wb_regwrite", 32'(seen[3].regwrite), 32'd1);
    check("addu_wb_regdst", 32'(seen[3].regdst), 32'd1);
    check("addu_wb_aluop", 32'(seen[3].aluop), 32'd0);

    // lw with two wait cycles
    seen.delete();
    run_instr(M_LW, 32'h8C220004, 2, 1'b0, 1'b0, -1);
    check("lw_states", state_trace(), 32'h0123336);
    check("lw_wb_memtoreg", 32'(seen[6].memtoreg), 32'd1);
    check("lw_wb_extop", 32'(seen[6].extop), 32'd1);

    // beq taken / not taken
    seen.delete();
    run_instr(M_BEQ, 32'h10220003, 0, 1'b1, 1'b0, -1);
    check("beq_taken_states", state_trace(), 32'h012);
    check("beq_taken_pc_we", 32'(seen[2].pc_we), 32'd1);
    check("beq_taken_npc_sel", 32'(seen[2].npc_sel), 32'd1);
    seen.delete();
    run_instr(M_BEQ, 32'h10220003, 0, 1'b0, 1'b0, -1);
    check("beq_not_taken_states", state_trace(), 32'h012);
    check("beq_not_taken_pc_we", 32'(seen[2].pc_we), 32'd0);

    // jal
    seen.delete();
    run_instr(M_JAL, 32'h0C000010, 0, 1'b0, 1'b0, -1);
    check("jal_states", state_trace(), 32'h01);
    check("jal_decode_pc_we", 32'(seen[1].pc_we), 32'd1);
    check("jal_decode_npc_sel", 32'(seen[1].npc_sel), 32'd2);
    check("jal_decode_regwrite", 32'(seen[1].regwrite), 32'd1);
    check("jal_decode_regdst", 32'(seen[1].regdst), 32'd2);
    check("jal_decode_memtoreg", 32'(seen[1].memtoreg), 32'd2);

    // bgezal taken / not taken
    seen.delete();
    run_instr(M_BGEZAL, 32'h04310008, 0, 1'b0, 1'b1, -1);
    check("bgezal_taken_regwrite", 32'(seen[2].regwrite), 32'd1);
    check("bgezal_taken_pc_we", 32'(seen[2].pc_we), 32'd1);
    seen.delete();
    run_instr(M_BGEZAL, 32'h04310008, 0, 1'b0, 1'b0, -1);
    check("bgezal_not_taken_regwrite", 32'(seen[2].regwrite), 32'd0);
    check("bgezal_not_taken_pc_we", 32'(seen[2].pc_we), 32'd0);

    // sb stalled in the write state, then reset
    run_instr(M_SB, 32'hA0220001, 5, 1'b0, 1'b0, 4);

    // unknown opcode 0x3F
    seen.delete();
    run_instr(M_NOP, 32'hFC000000, 0, 1'b0, 1'b0, -1);
    check("nop_states", state_trace(), 32'h01);
    check("nop_decode_pc_we", 32'(seen[1].pc_we), 32'd0);
    check("nop_decode_regwrite", 32'(seen[1].regwrite), 32'd0);
    check("nop_decode_memwrite", 32'(seen[1].memwrite), 32'd0);

    // randomized instruction stream with occasional reset aborts
    repeat (300) begin
      m       = mn_t'($urandom_range(0, 13));
      n       = $urandom_range(0, 3);
      len     = cycles_of(m, n);
      abort_k = ($urandom_range(0, 19) == 0) ? $urandom_range(1, len - 1) : -1;
      run_instr(m, make_instr(m), n, 1'($urandom), 1'($urandom), abort_k);
    end

    @(posedge clk); #1;
    check("expect_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
